// File: rtl/streebog_pkg.sv
// streebog_pkg
// Shared Streebog definitions used by the block packer and the hash core.
//   BLOCK_BITS : compression block size in bits
//   LEN_W      : width of a bit-length field covering 0..BLOCK_BITS
//   pad_mask   : keeps the message bits below a given length
//   pad_block  : zeroes bits at or above a length and sets the padding bit
package streebog_pkg;

  localparam int BLOCK_BITS = 512;
  localparam int LEN_W      = 10;

  // Ones in every bit position below len; a len of BLOCK_BITS keeps everything.
  function automatic logic [BLOCK_BITS-1:0] pad_mask(input logic [LEN_W-1:0] len);
    logic [BLOCK_BITS-1:0] ones;
    ones = '1;
    return ~(ones << len);
  endfunction

  // Shifting past the top of the block makes the padding bit vanish, so a
  // completely full final block comes back untouched.
  function automatic logic [BLOCK_BITS-1:0] pad_block(input logic [BLOCK_BITS-1:0] data,
                                                      input logic [LEN_W-1:0]      len);
    logic [BLOCK_BITS-1:0] one;
    one = BLOCK_BITS'(1);
    return (data & pad_mask(len)) | (one << len);
  endfunction

endpackage

// File: rtl/streebog_block_fifo.sv
// streebog_block_fifo
// Small register FIFO holding closed blocks for the packer.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   clear_i       : synchronous flush, wins over push and pop
//   push_i/data_i : write an entry; accepted when not full or when popping
//   pop_i         : remove the head entry (ignored when empty)
//   data_o        : head entry, stable until popped
//   valid_o       : FIFO not empty
//   full_o        : FIFO holds DEPTH entries
module streebog_block_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 523
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/streebog_block_packer.sv
// streebog_block_packer
// Packs IN_WIDTH-bit message words into 512-bit Streebog blocks and pads the
// final block of each message.
//   clk_i, rstn_i     : clock, asynchronous active-low reset
//   abort_i           : drop the partial block and every queued block
//   s_data_i/s_valid_i/s_ready_o/s_last_i/s_nbytes_i : word input stream
//   m_data_o/m_valid_o/m_ready_i/m_last_o/m_last_len_o : block output stream
//   busy_o            : a partial block is held or a block is queued
module streebog_block_packer
  import streebog_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_DEPTH = 2
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               abort_i,
  input  logic [IN_WIDTH-1:0]                s_data_i,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  input  logic                               s_last_i,
  input  logic [$clog2(IN_WIDTH/8+1)-1:0]    s_nbytes_i,
  output logic [511:0]                       m_data_o,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic                               m_last_o,
  output logic [9:0]                         m_last_len_o,
  output logic                               busy_o
);

  localparam int WPB     = BLOCK_BITS / IN_WIDTH;
  localparam int CNT_W   = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int ENTRY_W = BLOCK_BITS + 1 + LEN_W;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BLOCK_BITS-1:0] asm_q, asm_d;
  logic                  ready_q;
  logic                  closes, accept, push;
  logic                  fifo_full, fifo_valid;
  logic [BLOCK_BITS-1:0] blk, push_data;
  logic [LEN_W-1:0]      last_len, push_len;
  logic                  push_last;
  logic [ENTRY_W-1:0]    fifo_din, fifo_dout;

  // Only a block-closing beat needs FIFO space; a pop in the same cycle frees it.
  assign closes    = s_last_i || (cnt_q == CNT_W'(WPB - 1));
  assign s_ready_o = ready_q && (!closes || !fifo_full || m_ready_i);
  assign accept    = s_valid_i && s_ready_o && !abort_i;
  assign push      = accept && closes;

  // Merge the incoming word into its slot; slots above the counter may hold
  // stale words from an earlier block, which the final-block mask removes.
  always_comb begin
    blk = asm_q;
    for (int k = 0; k < WPB; k++) begin
      if (cnt_q == CNT_W'(k)) blk[k*IN_WIDTH +: IN_WIDTH] = s_data_i;
    end
    asm_d = accept ? blk : asm_q;

    last_len = LEN_W'(cnt_q) * LEN_W'(IN_WIDTH) + (LEN_W'(s_nbytes_i) << 3);

    if (s_last_i) begin
      push_data = pad_block(blk, last_len);
      push_len  = last_len;
      push_last = 1'b1;
    end else begin
      push_data = blk;
      push_len  = LEN_W'(BLOCK_BITS);
      push_last = 1'b0;
    end

    cnt_d = cnt_q;
    if (abort_i)     cnt_d = '0;
    else if (accept) cnt_d = closes ? '0 : cnt_q + CNT_W'(1);
  end

  // ready_q holds s_ready_o low until the first clock after reset release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ready_q <= 1'b1;
    end
  end

  assign fifo_din = {push_last, push_len, push_data};

  streebog_block_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (abort_i),
    .push_i  (push),
    .data_i  (fifo_din),
    .pop_i   (m_ready_i),
    .data_o  (fifo_dout),
    .valid_o (fifo_valid),
    .full_o  (fifo_full)
  );

  assign m_valid_o    = fifo_valid;
  assign m_data_o     = fifo_dout[BLOCK_BITS-1:0];
  assign m_last_len_o = fifo_dout[BLOCK_BITS +: LEN_W];
  assign m_last_o     = fifo_dout[ENTRY_W-1];
  assign busy_o       = (cnt_q != '0) || fifo_valid;

endmodule

// File: tb/tb_streebog_block_packer.sv
module tb_streebog_block_packer;

  typedef struct {
    logic [511:0] data;
    bit           last;
    int           len;
  } blk_t;

  typedef struct {
    int nWords;
    int nBytes;
    int expLen;
  } vec_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         abort = 1'b0;
  logic [63:0]  sData = '0;
  logic         sValid = 1'b0;
  logic         sReady;
  logic         sLast = 1'b0;
  logic [3:0]   sNbytes = '0;
  logic [511:0] mData;
  logic         mValid;
  logic         mReady = 1'b0;
  logic         mLast;
  logic [9:0]   mLastLen;
  logic         busy;

  logic [511:0] wData = '0;
  logic         wValid = 1'b0;
  logic         wReady;
  logic [511:0] wMData;
  logic         wMValid;
  logic         wMLast;
  logic [9:0]   wMLen;
  logic         wBusy;

  int checks = 0;
  int passes = 0;
  int readyMode = 1;
  int blocksSeen = 0;
  int lastLenSeen = -1;
  logic [511:0] lastDataSeen = '0;
  blk_t expQ[$];
  logic [7:0] curBytes[$];
  int curWords = 0;

  always #5 clk = ~clk;

  streebog_block_packer #(.IN_WIDTH(64), .OUT_DEPTH(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .abort_i(abort),
    .s_data_i(sData), .s_valid_i(sValid), .s_ready_o(sReady),
    .s_last_i(sLast), .s_nbytes_i(sNbytes),
    .m_data_o(mData), .m_valid_o(mValid), .m_ready_i(mReady),
    .m_last_o(mLast), .m_last_len_o(mLastLen), .busy_o(busy)
  );

  streebog_block_packer #(.IN_WIDTH(512), .OUT_DEPTH(2)) dut512 (
    .clk_i(clk), .rstn_i(rstn), .abort_i(abort),
    .s_data_i(wData), .s_valid_i(wValid), .s_ready_o(wReady),
    .s_last_i(1'b0), .s_nbytes_i(7'd0),
    .m_data_o(wMData), .m_valid_o(wMValid), .m_ready_i(1'b1),
    .m_last_o(wMLast), .m_last_len_o(wMLen), .busy_o(wBusy)
  );

  task automatic checkOutput(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Reference model: the message is a byte stream; each block is its bytes in
  // order, and a short final block gets a 0x01 byte right after the message.
  task automatic modelBeat();
    int nb;
    blk_t b;
    nb = sLast ? int'(sNbytes) : 8;
    for (int i = 0; i < nb; i++) curBytes.push_back(sData[8*i +: 8]);
    curWords++;
    if (sLast || curWords == 8) begin
      b.data = '0;
      for (int i = 0; i < curBytes.size(); i++) b.data[8*i +: 8] = curBytes[i];
      b.len  = 8 * curBytes.size();
      b.last = sLast;
      if (b.len < 512) b.data[b.len] = 1'b1;
      expQ.push_back(b);
      curBytes.delete();
      curWords = 0;
    end
  endtask

  task automatic compareBlock();
    blk_t e;
    if (expQ.size() == 0) begin
      checkOutput(1'b0, "unexpected_block", $sformatf("got len=%0d last=%0b, want no block", mLastLen, mLast));
    end else begin
      e = expQ.pop_front();
      checkOutput(mData == e.data && mLast == e.last && int'(mLastLen) == e.len, "block",
        $sformatf("got len=%0d last=%0b data=%h want len=%0d last=%0b data=%h",
                  mLastLen, mLast, mData, e.len, e.last, e.data));
    end
    blocksSeen++;
    if (mLast) begin
      lastLenSeen  = int'(mLastLen);
      lastDataSeen = mData;
    end
  endtask

  task automatic tick(output bit acc);
    @(negedge clk);
    acc = sValid && sReady && !abort;
    if (mValid && mReady) compareBlock();
    if (abort) begin
      expQ.delete();
      curBytes.delete();
      curWords = 0;
    end else if (acc) begin
      modelBeat();
    end
    @(posedge clk);
    #1;
    if (readyMode == 2) mReady = 1'($urandom_range(0, 1));
    else mReady = (readyMode == 1);
  endtask

  task automatic applyStimulus(input logic [63:0] d, input bit last, input int nb);
    bit acc;
    int n;
    sData = d; sLast = last; sNbytes = 4'(nb); sValid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      tick(acc);
      n++;
    end
    if (!acc) checkOutput(1'b0, "beat_timeout", $sformatf("beat not accepted after %0d cycles", n));
    sValid = 1'b0; sLast = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    readyMode = 1;
    mReady = 1'b1;
    n = 0;
    while ((expQ.size() != 0 || mValid) && n < 100) begin
      tick(acc);
      n++;
    end
    if (n >= 100) checkOutput(1'b0, "drain_timeout", $sformatf("queue=%0d valid=%0b", expQ.size(), mValid));
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    vec_t vecs[9];
    bit acc;
    logic [63:0]  pat;
    logic [511:0] expPat;
    logic [511:0] prevWord;

    vecs[0] = '{8, 8, 512};
    vecs[1] = '{3, 3, 152};
    vecs[2] = '{1, 0, 0};
    vecs[3] = '{2, 8, 128};
    vecs[4] = '{9, 1, 8};
    vecs[5] = '{16, 8, 512};
    vecs[6] = '{8, 0, 448};
    vecs[7] = '{1, 8, 64};
    vecs[8] = '{7, 5, 424};

    // Reset values
    #12;
    checkOutput(sReady == 1'b0, "reset_s_ready", $sformatf("got %0b want 0", sReady));
    checkOutput(mValid == 1'b0 && busy == 1'b0, "reset_valid_busy", $sformatf("got valid=%0b busy=%0b want 0 0", mValid, busy));
    checkOutput(mData == '0 && mLast == 1'b0 && mLastLen == '0, "reset_data",
      $sformatf("got last=%0b len=%0d want 0 0", mLast, mLastLen));
    rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput(sReady == 1'b1, "ready_after_reset", $sformatf("got %0b want 1", sReady));
    mReady = 1'b1;

    // Table-driven messages
    for (int v = 0; v < 9; v++) begin
      lastLenSeen = -1;
      for (int w = 0; w < vecs[v].nWords; w++)
        applyStimulus(rand64(), w == vecs[v].nWords - 1, vecs[v].nBytes);
      drain();
      checkOutput(lastLenSeen == vecs[v].expLen, $sformatf("vec%0d_len", v),
        $sformatf("got %0d want %0d", lastLenSeen, vecs[v].expLen));
    end

    // Exact 512-bit message of repeating bytes 00..07: no padding bit
    pat = 64'h0706050403020100;
    expPat = {8{pat}};
    for (int w = 0; w < 8; w++) applyStimulus(pat, w == 7, 8);
    drain();
    checkOutput(lastDataSeen == expPat && lastLenSeen == 512, "full_last_block",
      $sformatf("got len=%0d data=%h", lastLenSeen, lastDataSeen));

    // Empty message
    applyStimulus(rand64(), 1'b1, 0);
    drain();
    checkOutput(lastDataSeen == 512'd1 && lastLenSeen == 0, "empty_message",
      $sformatf("got len=%0d data=%h want len=0 data=1", lastLenSeen, lastDataSeen));

    // Backpressure: FIFO of two fills, closing beat of block 3 stalls
    readyMode = 0; mReady = 1'b0;
    blocksSeen = 0;
    for (int w = 0; w < 23; w++) applyStimulus(rand64(), 1'b0, 8);
    sData = rand64(); sValid = 1'b1; sLast = 1'b0; sNbytes = 4'd8;
    #1;
    checkOutput(sReady == 1'b0, "stall_on_close", $sformatf("got s_ready=%0b want 0", sReady));
    for (int i = 0; i < 3; i++) tick(acc);
    checkOutput(sReady == 1'b0 && !acc, "stall_holds", $sformatf("got s_ready=%0b acc=%0b want 0 0", sReady, acc));
    mReady = 1'b1;
    #1;
    checkOutput(sReady == 1'b1, "ready_with_pop", $sformatf("got %0b want 1", sReady));
    tick(acc);
    checkOutput(acc == 1'b1, "stalled_beat_accepted", $sformatf("got %0b want 1", acc));
    sValid = 1'b0;
    drain();
    checkOutput(blocksSeen == 3, "stall_block_count", $sformatf("got %0d want 3", blocksSeen));

    // Abort mid-block, then a fresh two-word message
    for (int w = 0; w < 5; w++) applyStimulus(rand64(), 1'b0, 8);
    checkOutput(busy == 1'b1, "busy_partial", $sformatf("got %0b want 1", busy));
    abort = 1'b1; sValid = 1'b1; sData = rand64(); sLast = 1'b1; sNbytes = 4'd8;
    tick(acc);
    abort = 1'b0; sValid = 1'b0; sLast = 1'b0;
    checkOutput(busy == 1'b0 && mValid == 1'b0, "abort_clears", $sformatf("got busy=%0b valid=%0b want 0 0", busy, mValid));
    blocksSeen = 0; lastLenSeen = -1;
    applyStimulus(rand64(), 1'b0, 8);
    applyStimulus(rand64(), 1'b1, 8);
    drain();
    checkOutput(blocksSeen == 1 && lastLenSeen == 128, "after_abort",
      $sformatf("got blocks=%0d len=%0d want 1 128", blocksSeen, lastLenSeen));

    // Random messages with random gaps and random backpressure
    readyMode = 2;
    for (int m = 0; m < 30; m++) begin
      int nw;
      nw = $urandom_range(1, 20);
      for (int w = 0; w < nw; w++) begin
        applyStimulus(rand64(), w == nw - 1, $urandom_range(0, 8));
        repeat ($urandom_range(0, 2)) tick(acc);
      end
    end
    drain();
    checkOutput(expQ.size() == 0, "random_all_delivered", $sformatf("got %0d pending want 0", expQ.size()));

    // IN_WIDTH=512: one block per clock
    prevWord = '0;
    for (int c = 0; c < 12; c++) begin
      for (int j = 0; j < 16; j++) wData[32*j +: 32] = $urandom;
      wValid = 1'b1;
      @(negedge clk);
      if (c > 0)
        checkOutput(wReady && wMValid && wMData == prevWord && !wMLast && wMLen == 10'd512, "w512_stream",
          $sformatf("got ready=%0b valid=%0b last=%0b len=%0d data=%h want 1 1 0 512 %h",
                    wReady, wMValid, wMLast, wMLen, wMData, prevWord));
      prevWord = wData;
      @(posedge clk); #1;
    end
    wValid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/streebog_block_packer.md
STREEBOG_BLOCK_PACKER -- requirements
Module: streebog_block_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64: input word width in bits; legal values 8, 16, 32, 64, 128, 256, 512.
REQ-002 SHALL have parameter OUT_DEPTH, default 2: output block FIFO depth, 1..4.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk_i and rstn_i.
REQ-004 SHALL have these ports, in this order:
- clk_i  in  1  clock
- rstn_i  in  1  async active-low reset
- abort_i  in  1  sync discard of partial block and FIFO contents
- s_data_i  in  IN_WIDTH  message word; byte 0 in bits [7:0]
- s_valid_i  in  1  word valid
- s_ready_o  out  1  word accepted when s_valid_i and s_ready_o are both high
- s_last_i  in  1  final word of the message
- s_nbytes_i  in  clog2(IN_WIDTH/8+1)  valid low bytes of the final word, 0..IN_WIDTH/8; ignored unless s_last_i
- m_data_o  out  512  padded block
- m_valid_o  out  1  block valid
- m_ready_i  in  1  block consumed when m_valid_o and m_ready_i are both high
- m_last_o  out  1  final block of the message
- m_last_len_o  out  10  message bits in the final block, 0..512
- busy_o  out  1  a partial block is held or the FIFO is non-empty

Function
REQ-005 SHALL define WPB = 512/IN_WIDTH; word k of a block SHALL occupy m_data_o[k*IN_WIDTH +: IN_WIDTH].
REQ-006 SHALL accumulate accepted words in an assembly register with a word counter 0..WPB-1 that wraps to 0 when a block closes.
REQ-007 SHALL close a block when either (a) word WPB-1 is accepted, or (b) a word with s_last_i is accepted.
REQ-008 SHALL, on closing a non-last block, push it to the FIFO with m_last_o=0 and m_last_len_o=512.
REQ-009 SHALL, on closing a last block, compute L = (word count before the last word)*IN_WIDTH + 8*s_nbytes_i.
REQ-010 SHALL, when L<512, zero all bits >= L, set bit L to 1, and push the block with m_last_o=1 and m_last_len_o=L.
REQ-011 SHALL, when L=512, push the block unpadded with m_last_o=1 and m_last_len_o=512; no extra block is generated.
REQ-012 SHALL, for s_last_i with s_nbytes_i=0 on word 0, emit a block with L=0 and m_data_o = 512'd1.
REQ-013 SHALL present a closed block on m_valid_o one clock after the accepting beat when the FIFO was empty; there is no combinational path from the s_* inputs to the m_* outputs.
REQ-014 SHALL drive s_ready_o low only while the beat would close a block and the FIFO is full with no pop in that cycle; non-closing beats are always accepted.
REQ-015 SHALL support push and pop in the same cycle on a full FIFO, giving 100% throughput: one word per clock at IN_WIDTH=512, and one block per WPB clocks otherwise.
REQ-016 SHALL keep m_data_o, m_last_o and m_last_len_o stable while m_valid_o is high and m_ready_i is low.
REQ-017 SHALL, on abort_i, in the next cycle clear the word counter, empty the FIFO, and drop m_valid_o; a beat in the abort_i cycle SHALL be discarded; abort_i has priority over all other events.
REQ-018 SHALL start a new message immediately after a last block closes; back-to-back messages need no idle cycle.

Reset
REQ-019 SHALL, while rstn_i is low, drive s_ready_o=0, m_valid_o=0, m_last_o=0, m_last_len_o=0, m_data_o=0, busy_o=0, and clear the counter and FIFO pointers.
REQ-020 SHALL drive s_ready_o=1 from the first clock after reset deassertion; a reset mid-message SHALL discard everything, with the same effect as abort_i.

Structure
REQ-021 SHALL place BLOCK_BITS=512, LEN_W=10 and the padding-mask function in the shared streebog package, which is also used by the hash core.
REQ-022 SHALL instantiate one sub-module, streebog_block_fifo (parametrised DEPTH and WIDTH=512+1+10).

Verification
REQ-023 IN_WIDTH=64: 8 words 0x00..07 repeated, s_last_i on word 7, s_nbytes_i=8 -> one block, m_last_o=1, m_last_len_o=512, no padding bit.
REQ-024 IN_WIDTH=64: 3 words, last word s_nbytes_i=3 -> m_last_len_o=152, bit 152=1, bits 153..511=0.
REQ-025 IN_WIDTH=64: single beat s_last_i=1, s_nbytes_i=0 -> m_data_o=512'd1, m_last_len_o=0, m_last_o=1.
REQ-026 OUT_DEPTH=2, m_ready_i=0: stream 24 words -> s_ready_o falls on the closing beat of block 3 and stays low until m_ready_i pulses; no word is lost or duplicated.
REQ-027 Mid-block abort_i after 5 words, then a fresh 2-word message with s_nbytes_i=8 -> only the new block appears, with m_last_len_o=128.
REQ-028 IN_WIDTH=512 continuous valid with m_ready_i=1 -> one block per clock, m_valid_o continuously high after the first cycle.
